// File: rtl/core_seq_pkg.sv
// Shared types and defaults for the multi-cycle execution sequencer.
package core_seq_pkg;

    localparam int ADDR_W_DEF      = 6;
    localparam int RET_W_DEF       = 16;
    localparam int WDOG_CYCLES_DEF = 16;

    localparam logic [3:0] HALT_OP = 4'hF;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_FETCH,
        SEQ_DECODE,
        SEQ_READ,
        SEQ_EXEC,
        SEQ_WB,
        SEQ_HALT,
        SEQ_ERR
    } seq_state_e;

    function automatic logic is_busy(seq_state_e s);
        return !(s inside {SEQ_IDLE, SEQ_HALT, SEQ_ERR});
    endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Sequencer <-> datapath handshake bundle; master is the sequencer side.
interface core_seq_ctrl_if
    import core_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RET_W  = RET_W_DEF
) ();

    logic              start;
    logic              halt_req;
    logic              instr_valid;
    logic [3:0]        instr_opcode;
    logic              next_instr;
    logic              dec_start;
    logic              dec_done;
    logic              rf_rd_req;
    logic              rf_op_done;
    logic              alu_data_valid;
    logic              rd_wr_en;
    logic              wb_en;
    logic [ADDR_W-1:0] pc;
    logic [RET_W-1:0]  retired;
    logic              busy;
    logic              halted;
    logic              err;

    modport master (
        input  start, halt_req, instr_valid, instr_opcode, dec_done,
               rf_op_done, alu_data_valid, rd_wr_en,
        output next_instr, dec_start, rf_rd_req, wb_en, pc, retired,
               busy, halted, err
    );

    modport slave (
        output start, halt_req, instr_valid, instr_opcode, dec_done,
               rf_op_done, alu_data_valid, rd_wr_en,
        input  next_instr, dec_start, rf_rd_req, wb_en, pc, retired,
               busy, halted, err
    );

endinterface

// File: rtl/core_seq_wdog.sv
// Per-state stall timer: reloads on clear, pulses timeout after WDOG_CYCLES enabled cycles.
module core_seq_wdog #(
    parameter int WDOG_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count reached in the WDOG_CYCLES-th cycle of the state
    assign timeout_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/decode/read/exec/writeback sequencer. Watchdog and ERR state
// are built only when CORE_SEQ_WDOG_EN is defined.
//   state  | meaning
//   IDLE   | out of reset, waiting for start
//   FETCH  | fetch request issued, waiting for instr_valid
//   DECODE | decode request issued, waiting for dec_done
//   READ   | register read requested, waiting for rf_op_done
//   EXEC   | waiting for alu_data_valid
//   WB     | one-cycle writeback, pc/retired advance
//   HALT   | stopped by halt opcode or halt_req
//   ERR    | watchdog expired (watchdog build only)
module core_seq_ctrl
    import core_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RET_W  = RET_W_DEF
`ifdef CORE_SEQ_WDOG_EN
    , parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
`endif
) (
    input  logic            clk,
    input  logic            reset,
    core_seq_ctrl_if.master bus
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    logic              halt_pend_q, halt_pend_d;
    logic              err_q, err_d;
    logic              next_instr_q, dec_start_q, rf_rd_req_q, wb_en_q;
    logic              busy_q, halted_q;
    logic              entry, start_ok, wdog_to;

    assign entry = (state_d != state_q);

`ifdef CORE_SEQ_WDOG_EN
    logic wait_st;
    assign wait_st = state_q inside {SEQ_FETCH, SEQ_DECODE, SEQ_READ, SEQ_EXEC};

    core_seq_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (entry),
        .en_i      (wait_st),
        .timeout_o (wdog_to)
    );
`else
    assign wdog_to = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        halt_pend_d = halt_pend_q;
        err_d       = err_q;
        start_ok    = 1'b0;

        case (state_q)
            SEQ_IDLE, SEQ_HALT, SEQ_ERR: begin
                if (bus.start) begin
                    start_ok  = 1'b1;
                    state_d   = SEQ_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                    err_d     = 1'b0;
                end
            end
            SEQ_FETCH: begin
                if (bus.instr_valid) begin
                    state_d = (bus.instr_opcode == HALT_OP) ? SEQ_HALT : SEQ_DECODE;
                end else if (wdog_to) begin
                    state_d = SEQ_ERR;
                end
            end
            SEQ_DECODE: begin
                if (bus.dec_done)     state_d = SEQ_READ;
                else if (wdog_to)     state_d = SEQ_ERR;
            end
            SEQ_READ: begin
                if (bus.rf_op_done)   state_d = SEQ_EXEC;
                else if (wdog_to)     state_d = SEQ_ERR;
            end
            SEQ_EXEC: begin
                if (bus.alu_data_valid) state_d = SEQ_WB;
                else if (wdog_to)       state_d = SEQ_ERR;
            end
            SEQ_WB: begin
                pc_d      = pc_q + ADDR_W'(1);
                retired_d = (retired_q == '1) ? retired_q : retired_q + RET_W'(1);
                state_d   = (halt_pend_q || bus.halt_req) ? SEQ_HALT : SEQ_FETCH;
            end
            default: state_d = SEQ_IDLE;
        endcase

        // A start always re-arms the pending halt from the current halt_req
        if (start_ok)                halt_pend_d = bus.halt_req;
        else if (is_busy(state_q))   halt_pend_d = halt_pend_q | bus.halt_req;
        if (entry && (state_d == SEQ_HALT)) halt_pend_d = 1'b0;

        if (entry && (state_d == SEQ_ERR))  err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEQ_IDLE;
            pc_q         <= '0;
            retired_q    <= '0;
            halt_pend_q  <= 1'b0;
            err_q        <= 1'b0;
            next_instr_q <= 1'b0;
            dec_start_q  <= 1'b0;
            rf_rd_req_q  <= 1'b0;
            wb_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            retired_q    <= retired_d;
            halt_pend_q  <= halt_pend_d;
            err_q        <= err_d;
            next_instr_q <= entry && (state_d == SEQ_FETCH);
            dec_start_q  <= entry && (state_d == SEQ_DECODE);
            rf_rd_req_q  <= (state_d == SEQ_READ);
            wb_en_q      <= (state_d == SEQ_WB) && bus.rd_wr_en;
            busy_q       <= is_busy(state_d);
            halted_q     <= (state_d == SEQ_HALT);
        end
    end

    assign bus.next_instr = next_instr_q;
    assign bus.dec_start  = dec_start_q;
    assign bus.rf_rd_req  = rf_rd_req_q;
    assign bus.wb_en      = wb_en_q;
    assign bus.pc         = pc_q;
    assign bus.retired    = retired_q;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed self-checking bench for core_seq_ctrl; a second narrow instance
// (ADDR_W=2, RET_W=2) shares the stimulus to exercise pc wrap and retired saturation.
module tb_core_seq_ctrl;
    import core_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    core_seq_ctrl_if #(.ADDR_W(6), .RET_W(16)) bus ();
    core_seq_ctrl_if #(.ADDR_W(2), .RET_W(2))  bus_s ();

    core_seq_ctrl #(.ADDR_W(6), .RET_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    core_seq_ctrl #(.ADDR_W(2), .RET_W(2)) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    assign bus_s.start          = bus.start;
    assign bus_s.halt_req       = bus.halt_req;
    assign bus_s.instr_valid    = bus.instr_valid;
    assign bus_s.instr_opcode   = bus.instr_opcode;
    assign bus_s.dec_done       = bus.dec_done;
    assign bus_s.rf_op_done     = bus.rf_op_done;
    assign bus_s.alu_data_valid = bus.alu_data_valid;
    assign bus_s.rd_wr_en       = bus.rd_wr_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt_a, cnt_b;

        reset                = 1'b1;
        bus.start            = 1'b0;
        bus.halt_req         = 1'b0;
        bus.instr_valid      = 1'b0;
        bus.instr_opcode     = 4'h0;
        bus.dec_done         = 1'b0;
        bus.rf_op_done       = 1'b0;
        bus.alu_data_valid   = 1'b0;
        bus.rd_wr_en         = 1'b0;
        step(2);

        check("rst_next_instr", bus.next_instr, 0);
        check("rst_dec_start",  bus.dec_start, 0);
        check("rst_rf_rd_req",  bus.rf_rd_req, 0);
        check("rst_wb_en",      bus.wb_en, 0);
        check("rst_pc",         bus.pc, 0);
        check("rst_retired",    bus.retired, 0);
        check("rst_busy",       bus.busy, 0);
        check("rst_halted",     bus.halted, 0);
        check("rst_err",        bus.err, 0);
        check("rst_halt_pend",  u_dut.halt_pend_q, 0);
        reset = 1'b0;
        step();
        check("idle_busy", bus.busy, 0);

        // Back-to-back instructions, every handshake immediate
        bus.instr_valid    = 1'b1;
        bus.dec_done       = 1'b1;
        bus.rf_op_done     = 1'b1;
        bus.alu_data_valid = 1'b1;
        bus.rd_wr_en       = 1'b1;
        bus.start          = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 5; k++) begin
                bus.start = (i == 2 && k == 2);
                check($sformatf("fast_next_instr_%0d_%0d", i, k), bus.next_instr, (k == 0));
                check($sformatf("fast_dec_start_%0d_%0d", i, k),  bus.dec_start, (k == 1));
                check($sformatf("fast_rf_rd_req_%0d_%0d", i, k),  bus.rf_rd_req, (k == 2));
                check($sformatf("fast_wb_en_%0d_%0d", i, k),      bus.wb_en, (k == 4));
                check($sformatf("fast_pc_%0d_%0d", i, k),         bus.pc, i);
                check($sformatf("fast_retired_%0d_%0d", i, k),    bus.retired, i);
                check($sformatf("fast_busy_%0d_%0d", i, k),       bus.busy, 1);
                check($sformatf("fast_err_%0d_%0d", i, k),        bus.err, 0);
                check($sformatf("small_pc_%0d_%0d", i, k),        bus_s.pc, i % 4);
                check($sformatf("small_retired_%0d_%0d", i, k),   bus_s.retired, (i > 3) ? 3 : i);
                step();
            end
        end
        bus.start = 1'b0;

        // Reset while stalled in EXEC abandons the instruction
        bus.alu_data_valid = 1'b0;
        step(3);
        check("stall_busy", bus.busy, 1);
        check("stall_pc",   bus.pc, 6);
        reset = 1'b1;
        bus.alu_data_valid = 1'b1;
        step();
        check("midrst_wb_en",      bus.wb_en, 0);
        check("midrst_pc",         bus.pc, 0);
        check("midrst_retired",    bus.retired, 0);
        check("midrst_busy",       bus.busy, 0);
        check("midrst_next_instr", bus.next_instr, 0);
        reset = 1'b0;
        step();

        // dec_done 3 cycles late, rf_op_done 2 cycles late: 10 cycles per instruction
        bus.dec_done   = 1'b0;
        bus.rf_op_done = 1'b0;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 10; c++) begin
            bus.dec_done   = (c == 4);
            bus.rf_op_done = (c == 7);
            check($sformatf("slow_next_instr_%0d", c), bus.next_instr, (c == 0));
            check($sformatf("slow_dec_start_%0d", c),  bus.dec_start, (c == 1));
            check($sformatf("slow_rf_rd_req_%0d", c),  bus.rf_rd_req, (c >= 5 && c <= 7));
            check($sformatf("slow_wb_en_%0d", c),      bus.wb_en, (c == 9));
            cnt_a += int'(bus.dec_start);
            cnt_b += int'(bus.rf_rd_req);
            step();
        end
        check("slow_next_fetch",     bus.next_instr, 1);
        check("slow_pc",             bus.pc, 1);
        check("slow_retired",        bus.retired, 1);
        check("slow_dec_start_cnt",  cnt_a, 1);
        check("slow_rf_rd_req_cnt",  cnt_b, 3);

        // Halt opcode at pc 3
        bus.dec_done   = 1'b1;
        bus.rf_op_done = 1'b1;
        step(10);
        check("hop_pc_before",   bus.pc, 3);
        check("hop_fetch",       bus.next_instr, 1);
        bus.instr_opcode = 4'hF;
        step();
        check("hop_halted",      bus.halted, 1);
        check("hop_busy",        bus.busy, 0);
        check("hop_retired",     bus.retired, 3);
        check("hop_pc",          bus.pc, 3);
        check("hop_next_instr",  bus.next_instr, 0);
        bus.instr_opcode = 4'h0;
        step(2);
        check("hop_stay_halted", bus.halted, 1);
        check("hop_stay_idle",   bus.next_instr, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("restart_pc",      bus.pc, 0);
        check("restart_retired", bus.retired, 0);
        check("restart_halted",  bus.halted, 0);
        check("restart_fetch",   bus.next_instr, 1);
        check("restart_busy",    bus.busy, 1);

        // halt_req during EXEC: writeback completes, then HALT
        step(3);
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        check("hreq_wb_en", bus.wb_en, 1);
        step();
        check("hreq_halted",  bus.halted, 1);
        check("hreq_retired", bus.retired, 1);
        check("hreq_pc",      bus.pc, 1);
        cnt_a = 0;
        for (int c = 0; c < 6; c++) begin
            cnt_a += int'(bus.next_instr);
            step();
        end
        check("hreq_no_fetch",    cnt_a, 0);
        check("hreq_still_halt",  bus.halted, 1);

        // start together with halt_req in IDLE: one instruction then HALT
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        bus.start    = 1'b1;
        bus.halt_req = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.halt_req = 1'b0;
        check("sh_fetch", bus.next_instr, 1);
        step(5);
        check("sh_halted",  bus.halted, 1);
        check("sh_retired", bus.retired, 1);

        // halt_req while halted is ignored
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        check("hh_halted", bus.halted, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("hh_fetch", bus.next_instr, 1);
        check("hh_pc0",   bus.pc, 0);
        step(5);
        check("hh_next_fetch", bus.next_instr, 1);
        check("hh_not_halted", bus.halted, 0);
        check("hh_pc1",        bus.pc, 1);

        // Stall in EXEC
        bus.alu_data_valid = 1'b0;
        step(3);
`ifdef CORE_SEQ_WDOG_EN
        step(15);
        check("wd_err_before", bus.err, 0);
        check("wd_busy_before", bus.busy, 1);
        step();
        check("wd_err",    bus.err, 1);
        check("wd_busy",   bus.busy, 0);
        check("wd_state",  u_dut.state_q, SEQ_ERR);
        check("wd_wb_en",  bus.wb_en, 0);
        bus.start          = 1'b1;
        bus.alu_data_valid = 1'b1;
        step();
        bus.start = 1'b0;
        check("wd_rec_err",     bus.err, 0);
        check("wd_rec_pc",      bus.pc, 0);
        check("wd_rec_retired", bus.retired, 0);
        check("wd_rec_fetch",   bus.next_instr, 1);
        check("wd_rec_busy",    bus.busy, 1);
`else
        step(40);
        check("nowd_err",   bus.err, 0);
        check("nowd_busy",  bus.busy, 1);
        check("nowd_wb_en", bus.wb_en, 0);
        bus.alu_data_valid = 1'b1;
        step();
        check("nowd_wb_after", bus.wb_en, 1);
        check("nowd_err_after", bus.err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Multi-cycle execution sequencer for the single-issue RISC-V datapath. It steps each instruction through fetch, decode, register read, ALU execute and writeback by handshaking with the instruction memory, decoder, register file and ALU. It owns the program counter, a retired-instruction counter, halt control and an optional stall watchdog. It sits beside the datapath in the top level and replaces free-running `next_instr`/`op_done` chaining.

## Interface
Parameters:
- `ADDR_W`, 6: PC width (64-entry instruction memory).
- `RET_W`, 16: retired-instruction counter width.
- `WDOG_CYCLES`, 16: stall limit per wait state (used only with the watchdog).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin execution from PC 0; honoured in IDLE, HALT and ERR.
- `halt_req` in 1: stop after the current instruction retires.
- `instr_valid` in 1: instruction memory has the fetched word.
- `instr_opcode` in 4: opcode field of the fetched word.
- `next_instr` out 1: one-cycle fetch request to the instruction memory.
- `dec_start` out 1: one-cycle decode request.
- `dec_done` in 1: decoder outputs are stable.
- `rf_rd_req` out 1: level request for a register read.
- `rf_op_done` in 1: register file operands are valid.
- `alu_data_valid` in 1: ALU result is valid.
- `rd_wr_en` in 1: decoded instruction writes rd.
- `wb_en` out 1: register file write strobe.
- `pc` out ADDR_W: address of the current instruction.
- `retired` out RET_W: count of instructions retired.
- `busy` out 1: the FSM is not in IDLE, HALT or ERR.
- `halted` out 1: the FSM is in HALT.
- `err` out 1: watchdog fired (sticky).

## Operation
- States: IDLE, FETCH, DECODE, READ, EXEC, WB, HALT, ERR. ERR exists only with the watchdog.
- IDLE: on `start`, go to FETCH.
- FETCH: `next_instr` is high in the first cycle only. Wait for `instr_valid`. If `instr_opcode`==HALT_OP (4'hF), go to HALT; the halt instruction is not retired. Otherwise go to DECODE.
- DECODE: `dec_start` is high in the first cycle only. Wait for `dec_done`, then go to READ.
- READ: `rf_rd_req` is high for the whole state. Wait for `rf_op_done`, then go to EXEC.
- EXEC: wait for `alu_data_valid`, then go to WB.
- WB: `wb_en` = `rd_wr_en` for exactly one cycle.
  - `pc` = `pc`+1, wrapping from 2^ADDR_W−1 to 0.
  - `retired`+1, saturating at all-ones.
  - If `halt_pend` is set, go to HALT; otherwise go to FETCH.
- `halt_pend` latches `halt_req` in any busy state, and also in the cycle `start` is accepted. It clears on entry to HALT.
- HALT: `halted`=1. `start` clears `pc` and `retired` and goes to FETCH.
- Handshake inputs are sampled only in their own state and ignored elsewhere.

## Timing
- Reset: state IDLE. All outputs and `halt_pend` are 0.
- Outputs are registered and decoded from state plus a first-cycle flag.
- Minimum latency is 5 cycles per instruction, when every handshake responds in the state's first cycle. `start` to first `next_instr` is 1 cycle.
- Simultaneous events:
  - `reset` overrides everything.
  - `start` is ignored while busy.
  - `start` with `halt_req` in IDLE executes exactly one instruction, then halts.
  - `halt_req` in IDLE, HALT or ERR is ignored.
- Reset mid-instruction abandons it. No `wb_en` is issued.

## Configuration
- `CORE_SEQ_WDOG_EN` defined:
  - A per-state cycle counter clears on every state entry.
  - If FETCH, DECODE, READ or EXEC spends WDOG_CYCLES cycles without its handshake, go to ERR with `err`=1.
  - ERR exits only via `start` (clears `err`, `pc`, `retired`) or `reset`.
- Not defined: wait states stall indefinitely, ERR is absent, and `err` is tied 0.

## Structure
- `core_seq_pkg` holds the `seq_state_e` enum, `HALT_OP`, and the default `ADDR_W`/`RET_W`.
- Sub-module `core_seq_wdog`: clear and enable inputs, a timeout pulse output, parameterised by WDOG_CYCLES. It is instantiated only under the macro.

## Test plan
- Reset, then `start`, with all handshakes responding same-cycle and `rd_wr_en`=1: `next_instr` pulses every 5 cycles, `wb_en` pulses once per instruction, and `pc` reads 0,1,2…
- `dec_done` delayed 3 cycles, then `rf_op_done` delayed 2: 10 cycles per instruction, `dec_start` pulses once, and `rf_rd_req` is high exactly 3 cycles.
- `instr_opcode`=4'hF at `pc`=3: HALT entered, `retired`=3, `halted`=1. A following `start` sets `pc`=0 and `retired`=0.
- `halt_req` pulsed during EXEC of instruction 0: WB completes, then HALT with `retired`=1 and no further `next_instr`.
- ADDR_W=2, run 5 instructions: `pc` goes 0,1,2,3,0,1, and `retired` with RET_W=2 saturates at 3.
- Watchdog on, `alu_data_valid` held 0: `err`=1 after 16 EXEC cycles and the FSM is in ERR. `start` recovers it with `err`=0.
